// File: rtl/adc_rx_pkg.sv
// Shared types and helpers for the ADC receive path.
package adc_rx_pkg;
    localparam int ADC_DATA_W = 8;

    typedef logic [ADC_DATA_W-1:0] sample_t;

    function automatic int cnt_w(input int clk_factor);
        return (clk_factor > 1) ? $clog2(clk_factor) : 1;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO; head_data reads 0 while empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        head_data = empty ? '0 : mem_q[rd_ptr_q];
        level     = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past the empty gate.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/adc_rx.sv
// ADC receiver: divides clk into adc_clk, captures the registered ADC bus once per
// period at SAMPLE_PHASE, and streams samples out through a FWFT FIFO.
module adc_rx
    import adc_rx_pkg::*;
#(
    parameter int CLK_FACTOR   = 10,
    parameter int DATA_W       = ADC_DATA_W,
    parameter int SAMPLE_PHASE = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_W-1:0]             adc_din,
    output logic                          adc_clk,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          clr_ovf
);
    localparam int CW = cnt_w(CLK_FACTOR);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              adc_clk_q, adc_clk_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              ovf_q, ovf_d;
    logic              capture, pop, drop, fifo_full, fifo_empty;

    always_comb begin
        din_d     = adc_din;
        cnt_d     = '0;
        adc_clk_d = 1'b0;
        if (en) begin
            cnt_d     = (cnt_q == CW'(CLK_FACTOR-1)) ? '0 : cnt_q + CW'(1);
            adc_clk_d = (cnt_q >= CW'(CLK_FACTOR/2));
        end
        capture = en && (cnt_q == CW'(SAMPLE_PHASE));
        pop     = m_valid && m_ready;
        // A pop in the same cycle frees the slot, so only a pop-less full push drops.
        drop    = capture && fifo_full && !pop;
        ovf_d   = drop || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            adc_clk_q <= 1'b0;
            din_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            adc_clk_q <= adc_clk_d;
            din_q     <= din_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (din_q),
        .full      (fifo_full),
        .pop       (m_ready),
        .head_data (m_data),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign m_valid  = !fifo_empty;
    assign adc_clk  = adc_clk_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_adc_rx.sv
// Directed bench for adc_rx: divider timing, capture, FIFO drain/fill, overflow, reset.
module tb_adc_rx;
    import adc_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    sample_t    adc_din;
    logic       adc_clk;
    sample_t    m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       overflow;
    logic       clr_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic    collect = 1'b0;
    sample_t got_q[$];

    adc_rx #(
        .CLK_FACTOR   (10),
        .DATA_W       (8),
        .SAMPLE_PHASE (8),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .adc_din  (adc_din),
        .adc_clk  (adc_clk),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (collect && m_valid && m_ready) got_q.push_back(m_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ADC model: a new ramp value appears at each adc_clk rise (cycle 6 of each period).
    function automatic sample_t din_of(input int c);
        return (c < 6) ? 8'h00 : 8'((c - 6) / 10);
    endfunction

    initial begin
        int hi_cnt, rises, max_lvl, first_hi;
        logic prev_clk;

        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; adc_din = '0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_adc_clk", adc_clk, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_overflow", overflow, 0);

        // Ramp with a ready consumer.
        tick();
        rst_n = 1'b1; collect = 1'b1;
        hi_cnt = 0; rises = 0; max_lvl = 0; prev_clk = 1'b0;
        for (int c = 0; c < 60; c++) begin
            adc_din = din_of(c);
            @(negedge clk);
            if (c == 5) chk("t1_clk_lo_c5", adc_clk, 0);
            if (c == 6) chk("t1_clk_hi_c6", adc_clk, 1);
            if (c == 8) chk("t1_valid_c8", m_valid, 0);
            if (c == 9) begin
                chk("t1_valid_c9", m_valid, 1);
                chk("t1_data_c9", m_data, 8'h00);
            end
            if (c == 10) chk("t1_valid_c10", m_valid, 0);
            if (c >= 10 && c < 50) begin
                if (adc_clk) hi_cnt++;
                if (adc_clk && !prev_clk) rises++;
            end
            prev_clk = adc_clk;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            tick();
        end
        collect = 1'b0;
        chk("t1_duty_high", hi_cnt, 20);
        chk("t1_rises", rises, 4);
        chk("t1_max_level", (max_lvl <= 1), 1);
        chk("t1_count", got_q.size(), 6);
        foreach (got_q[i]) chk("t1_ramp", got_q[i], i);

        // Enable pulse of exactly three periods.
        en = 1'b0;
        repeat (12) tick();
        chk("t2_idle_level", level, 0);
        chk("t2_idle_clk", adc_clk, 0);
        got_q.delete();
        collect = 1'b1; adc_din = 8'hA5; first_hi = -1;
        for (int c = 0; c < 40; c++) begin
            en = (c < 30);
            @(negedge clk);
            if (adc_clk && first_hi < 0) first_hi = c;
            if (c == 31) chk("t2_clk_off", adc_clk, 0);
            tick();
        end
        collect = 1'b0;
        chk("t2_first_rise", first_hi, 6);
        chk("t2_count", got_q.size(), 3);
        foreach (got_q[i]) chk("t2_data", got_q[i], 8'hA5);

        // Stall, overflow, clear priority, full push with pop, then drain.
        got_q.delete();
        for (int c = 0; c < 260; c++) begin
            adc_din = din_of(c);
            en      = (c < 220);
            m_ready = (c == 218) || (c >= 220);
            clr_ovf = (c == 208) || (c == 210);
            if (c == 220) collect = 1'b1;
            @(negedge clk);
            if (c == 159) chk("t3_level_full", level, 16);
            if (c == 168) begin
                chk("t3_ovf_before", overflow, 0);
                chk("t3_level_sat", level, 16);
            end
            if (c == 169) chk("t3_ovf_set", overflow, 1);
            if (c == 209) chk("t5_set_beats_clr", overflow, 1);
            if (c == 210) chk("t5_ovf_held", overflow, 1);
            if (c == 211) chk("t5_clr", overflow, 0);
            if (c == 218) begin
                chk("t4_head_valid", m_valid, 1);
                chk("t4_head_data", m_data, 8'h00);
            end
            if (c == 219) begin
                chk("t4_level_kept", level, 16);
                chk("t4_no_ovf", overflow, 0);
            end
            tick();
        end
        collect = 1'b0;
        clr_ovf = 1'b0;
        chk("t3_drain_count", got_q.size(), 16);
        for (int i = 0; i < 15 && i < got_q.size(); i++) chk("t3_order", got_q[i], i + 1);
        if (got_q.size() == 16) chk("t4_pushed_sample", got_q[15], 8'd21);
        chk("t3_drain_level", level, 0);

        // Asynchronous reset in the middle of a burst.
        m_ready = 1'b0;
        for (int c = 0; c < 78; c++) begin
            adc_din = din_of(c);
            en = 1'b1;
            @(negedge clk);
            if (c == 69) chk("t6_level7", level, 7);
            if (c == 77) begin
                chk("t6_clk_hi_pre", adc_clk, 1);
                #2 rst_n = 1'b0;
                #1;
                chk("t6_rst_valid", m_valid, 0);
                chk("t6_rst_level", level, 0);
                chk("t6_rst_ovf", overflow, 0);
                chk("t6_rst_clk", adc_clk, 0);
                chk("t6_rst_data", m_data, 0);
            end
            tick();
        end
        repeat (2) tick();
        rst_n = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            adc_din = din_of(c);
            @(negedge clk);
            if (c == 8) chk("t6_post_valid_c8", m_valid, 0);
            if (c == 9) begin
                chk("t6_post_valid_c9", m_valid, 1);
                chk("t6_post_data0", m_data, 8'h00);
            end
            if (c == 19) chk("t6_post_data1", m_data, 8'h01);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
